// File: rtl/ula_video_if.sv
// Video RAM bus and video output signals of the ULA video generator.
// FLOATING_BUS_EN adds the floatBus output.
interface ula_video_if;
    logic [2:0]  border;
    logic [7:0]  vmmData;
    logic [12:0] vmmAddr;
    logic        frameInt;
    logic        mayContend;
    logic [1:0]  sync;
    logic [8:0]  rgb;
`ifdef FLOATING_BUS_EN
    logic [7:0]  floatBus;

    modport master (
        input  border, vmmData,
        output vmmAddr, frameInt, mayContend, sync, rgb, floatBus
    );
    modport slave (
        output border, vmmData,
        input  vmmAddr, frameInt, mayContend, sync, rgb, floatBus
    );
`else
    modport master (
        input  border, vmmData,
        output vmmAddr, frameInt, mayContend, sync, rgb
    );
    modport slave (
        output border, vmmData,
        input  vmmAddr, frameInt, mayContend, sync, rgb
    );
`endif
endinterface

// File: rtl/ula_video.sv
// ZX-style ULA video generator: raster counters, VRAM fetch, pixel shifter, sync and frame interrupt.
// Optional FLOATING_BUS_EN exposes fetched VRAM bytes on floatBus.
module ula_video #(
    parameter int H_TOTAL    = 448,
    parameter int V_TOTAL    = 312,
    parameter int INT_LINE   = 248,
    parameter int INT_START  = 0,
    parameter int INT_LENGTH = 32,
    parameter int HS_START   = 344,
    parameter int HS_LENGTH  = 32,
    parameter int VS_START   = 248,
    parameter int VS_LENGTH  = 4,
    parameter int FLASH_BITS = 5
) (
    input logic         clock,
    input logic         reset,
    ula_video_if.master bus
);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_H0  = 10'(HS_START);
    localparam logic [9:0] HS_H1  = 10'(HS_START + HS_LENGTH - 1);
    localparam logic [9:0] VS_V0  = 10'(VS_START);
    localparam logic [9:0] VS_V1  = 10'(VS_START + VS_LENGTH - 1);
    localparam logic [9:0] INT_V  = 10'(INT_LINE);
    localparam logic [9:0] INT_H0 = 10'(INT_START);
    // Last source hCount of the pulse; capped so the registered pulse ends on H_TOTAL-1.
    localparam int         INT_END_RAW = INT_START + INT_LENGTH - 1;
    localparam int         INT_END     = (INT_END_RAW > H_TOTAL - 2) ? H_TOTAL - 2 : INT_END_RAW;
    localparam logic [9:0] INT_H1 = 10'(INT_END);
    localparam logic       INT_ON = (INT_LENGTH > 0) && (INT_END >= INT_START);

    function automatic logic inWindow(input logic [9:0] v, input logic [9:0] lo,
                                      input logic [9:0] hi);
        return (v - lo) <= (hi - lo);
    endfunction

    // Colour is {g, r, b}; the middle bit of each gun only lights when bright.
    function automatic logic [8:0] expandRgb(input logic [2:0] grb, input logic bright);
        return {grb[1], grb[1] & bright, grb[1],
                grb[2], grb[2] & bright, grb[2],
                grb[0], grb[0] & bright, grb[0]};
    endfunction

    logic [9:0]            hCount;
    logic [9:0]            vCount;
    logic [FLASH_BITS-1:0] fCount;

    always_ff @(posedge clock) begin
        if (reset) begin
            hCount <= '0;
            vCount <= '0;
            fCount <= '0;
        end else if (hCount == H_LAST) begin
            hCount <= '0;
            if (vCount == V_LAST) begin
                vCount <= '0;
                fCount <= fCount + 1'b1;
            end else begin
                vCount <= vCount + 1'b1;
            end
        end else begin
            hCount <= hCount + 1'b1;
        end
    end

    logic displayArea;
    logic bmpPhase;
    logic attrPhase;
    logic loadPhase;
    logic hBlank;
    logic vBlank;
    logic syncActive;
    logic intWindow;

    assign displayArea = (hCount < 10'd256) && (vCount < 10'd192);
    assign bmpPhase    = hCount[3] & ~hCount[1] & hCount[0];
    assign attrPhase   = hCount[3] &  hCount[1] & hCount[0];
    assign loadPhase   = (hCount[2:0] == 3'd4);
    assign hBlank      = inWindow(hCount, 10'd320, 10'd415);
    assign vBlank      = inWindow(vCount, 10'd248, 10'd255);
    assign syncActive  = inWindow(hCount, HS_H0, HS_H1) || inWindow(vCount, VS_V0, VS_V1);
    assign intWindow   = INT_ON && (vCount == INT_V) && inWindow(hCount, INT_H0, INT_H1);

    // Bitmap address on even fetch slots, attribute address (0x1800 region) on odd ones.
    assign bus.vmmAddr = {hCount[1] ? {3'b110, vCount[7:6]} : {vCount[7:6], vCount[2:0]},
                          vCount[5:3], hCount[7:4], hCount[2]};

    // Stage p0: fetch capture, shifter and attribute latch
    logic       videoEnable;
    logic [7:0] bitmapByte;
    logic [7:0] attrByte;
    logic [7:0] shifter;
    logic [7:0] attr;

    always_ff @(posedge clock) begin
        if (reset) begin
            videoEnable <= 1'b0;
            bitmapByte  <= '0;
            attrByte    <= '0;
            shifter     <= '0;
            attr        <= '0;
        end else begin
            if (hCount[3]) videoEnable <= displayArea;
            if (videoEnable && bmpPhase) bitmapByte <= bus.vmmData;
            if (videoEnable && attrPhase) attrByte <= bus.vmmData;
            if (loadPhase && videoEnable) shifter <= bitmapByte;
            else shifter <= {shifter[6:0], 1'b0};
            if (loadPhase) attr <= videoEnable ? attrByte : {2'b00, bus.border, 3'b000};
        end
    end

    logic       ink;
    logic [2:0] colour;

    assign ink    = shifter[7] ^ (fCount[FLASH_BITS-1] & attr[7]);
    assign colour = ink ? attr[2:0] : attr[5:3];

    // Stage p1: registered video outputs
    logic [8:0] rgb_p1;
    logic [1:0] sync_p1;
    logic       frameInt_p1;
    logic       mayContend_p1;

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_p1        <= '0;
            sync_p1       <= 2'b11;
            frameInt_p1   <= 1'b1;
            mayContend_p1 <= 1'b1;
        end else begin
            rgb_p1        <= (hBlank || vBlank) ? 9'd0 : expandRgb(colour, attr[6]);
            sync_p1       <= {1'b1, ~syncActive};
            frameInt_p1   <= ~intWindow;
            mayContend_p1 <= ~(displayArea && (hCount[3:0] > 4'd3));
        end
    end

    assign bus.rgb        = rgb_p1;
    assign bus.sync       = sync_p1;
    assign bus.frameInt   = frameInt_p1;
    assign bus.mayContend = mayContend_p1;

`ifdef FLOATING_BUS_EN
    logic [7:0] floatBus_p1;

    always_ff @(posedge clock) begin
        if (reset) floatBus_p1 <= 8'hFF;
        else if (videoEnable && (bmpPhase || attrPhase)) floatBus_p1 <= bus.vmmData;
        else floatBus_p1 <= 8'hFF;
    end

    assign bus.floatBus = floatBus_p1;
`endif
endmodule

// File: tb/tb_ula_video.sv
// Scoreboard bench for ula_video using a shortened 40-line frame and a 1-bit flash counter.
// Expected values are keyed by cycle count since reset release; a monitor pops them each cycle.
module tb_ula_video;
    localparam int HT = 448;
    localparam int VT = 40;
    localparam int FR = HT * VT;

    localparam int F_RGB = 0, F_SYNC = 1, F_INT = 2, F_MAYC = 3, F_HC = 4, F_VC = 5;
    localparam int F_FC = 6, F_FLOAT = 7, F_INTLOW = 8, F_INTFALL = 9, F_ADDR = 10;

    logic clock;
    logic reset;
    ula_video_if vbus ();

    ula_video #(
        .H_TOTAL(HT), .V_TOTAL(VT), .INT_LINE(20), .INT_START(0), .INT_LENGTH(32),
        .HS_START(344), .HS_LENGTH(32), .VS_START(30), .VS_LENGTH(4), .FLASH_BITS(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (vbus.master)
    );

    typedef struct {
        int    at;
        int    field;
        int    expv;
        string name;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    intLow = 0;
    int    intFalls = 0;
    logic  intPrev = 1'b1;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // VRAM model: one clock read latency; attribute per character-row band.
    always @(posedge clock) begin
        if (vbus.vmmAddr[12:10] == 3'b110) begin
            case (vbus.vmmAddr[7:5])
                3'b001:  vbus.vmmData <= 8'h87;
                3'b010:  vbus.vmmData <= 8'h47;
                3'b011:  vbus.vmmData <= 8'h38;
                default: vbus.vmmData <= 8'h07;
            endcase
        end else begin
            vbus.vmmData <= 8'hAA;
        end
    end

    function automatic int actualOf(input int field);
        case (field)
            F_RGB:     return int'(vbus.rgb);
            F_SYNC:    return int'(vbus.sync);
            F_INT:     return int'(vbus.frameInt);
            F_MAYC:    return int'(vbus.mayContend);
            F_HC:      return int'(dut.hCount);
            F_VC:      return int'(dut.vCount);
            F_FC:      return int'(dut.fCount);
`ifdef FLOATING_BUS_EN
            F_FLOAT:   return int'(vbus.floatBus);
`endif
            F_INTLOW:  return intLow;
            F_INTFALL: return intFalls;
            F_ADDR:    return int'(vbus.vmmAddr);
            default:   return -1;
        endcase
    endfunction

    task automatic expectAt(input int at, input int field, input int expv, input string name);
        item_t it;
        int    idx;
        it  = '{at, field, expv, name};
        idx = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].at > at) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, it);
    endtask

    // Registered outputs seen at cycle p+1 describe raster position p.
    task automatic expectOut(input int p, input int field, input int expv, input string name);
        expectAt(p + 1, field, expv, name);
    endtask

    // Monitor
    initial begin
        item_t it;
        int    act;
        forever begin
            @(posedge clock);
            if (reset) begin
                cyc      = 0;
                intLow   = 0;
                intFalls = 0;
                intPrev  = 1'b1;
            end else begin
                cyc++;
            end
            @(negedge clock);
            if (!reset && cyc > 0) begin
                if (vbus.frameInt == 1'b0) begin
                    intLow++;
                    if (intPrev) intFalls++;
                end
                intPrev = vbus.frameInt;
            end
            while (sb.size() != 0 && sb[0].at <= cyc) begin
                it = sb.pop_front();
                checks++;
                if (it.at < cyc) begin
                    errors++;
                    $display("FAIL %s: check for cycle %0d skipped (now %0d)", it.name, it.at, cyc);
                end else begin
                    act = actualOf(it.field);
                    if (act != it.expv) begin
                        errors++;
                        $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                                 it.name, cyc, act, it.expv);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Stimulus
    initial begin
        int n;
        reset       = 1'b1;
        vbus.border = 3'b010;

        expectAt(0, F_RGB, 0, "reset_rgb");
        expectAt(0, F_SYNC, 3, "reset_sync");
        expectAt(0, F_INT, 1, "reset_int");
        expectAt(0, F_MAYC, 1, "reset_mayContend");
        expectAt(0, F_HC, 0, "reset_hCount");

        expectOut(3, F_RGB, 9'h000, "l0_pre_border");
        expectOut(3, F_MAYC, 1, "l0_mayc_h3");
        expectOut(4, F_MAYC, 0, "l0_mayc_h4");
        expectOut(5, F_RGB, 9'h140, "l0_border_h5");
        expectOut(12, F_RGB, 9'h140, "l0_border_h12");
        expectOut(13, F_RGB, 9'h16D, "l0_pix0_ink");
        expectOut(14, F_RGB, 9'h000, "l0_pix1_paper");
        expectOut(15, F_RGB, 9'h16D, "l0_pix2_ink");
        expectOut(15, F_MAYC, 0, "l0_mayc_h15");
        expectOut(16, F_MAYC, 1, "l0_mayc_h16");
        expectOut(20, F_RGB, 9'h000, "l0_pix7_paper");
        expectOut(21, F_RGB, 9'h16D, "l0_pix8_ink");
        expectOut(255, F_MAYC, 0, "l0_mayc_h255");
        expectOut(256, F_MAYC, 1, "l0_mayc_h256");
        expectOut(261, F_RGB, 9'h16D, "l0_lastbyte_ink");
        expectOut(268, F_RGB, 9'h000, "l0_lastbyte_paper");
        expectOut(269, F_RGB, 9'h140, "l0_right_border");
        expectOut(319, F_RGB, 9'h140, "l0_border_h319");
        expectOut(320, F_RGB, 9'h000, "l0_hblank_h320");
        expectOut(415, F_RGB, 9'h000, "l0_hblank_h415");
        expectOut(416, F_RGB, 9'h140, "l0_border_h416");
        expectOut(343, F_SYNC, 3, "hsync_before");
        expectOut(344, F_SYNC, 2, "hsync_start");
        expectOut(375, F_SYNC, 2, "hsync_end");
        expectOut(376, F_SYNC, 3, "hsync_after");
        expectOut(HT + 13, F_RGB, 9'h16D, "l1_pix0_ink");
`ifdef FLOATING_BUS_EN
        expectOut(9, F_FLOAT, 8'hAA, "float_bitmap_h9");
        expectOut(10, F_FLOAT, 8'hFF, "float_idle_h10");
        expectOut(11, F_FLOAT, 8'h07, "float_attr_h11");
        expectOut(253, F_FLOAT, 8'hAA, "float_bitmap_h253");
        expectOut(265, F_FLOAT, 8'hFF, "float_border_h265");
`endif
        expectAt(9 * HT + 10, F_ADDR, 13'h1820, "addr_attr_v9_h10");
        expectAt(9 * HT + 12, F_ADDR, 13'h0121, "addr_bitmap_v9_h12");
        expectOut(8 * HT + 13, F_RGB, 9'h16D, "flash_f0_ink");
        expectOut(8 * HT + 14, F_RGB, 9'h000, "flash_f0_paper");
        expectOut(16 * HT + 13, F_RGB, 9'h1FF, "bright_ink");
        expectOut(16 * HT + 14, F_RGB, 9'h000, "bright_paper");
        expectOut(24 * HT + 13, F_RGB, 9'h000, "inv_ink_black");
        expectOut(24 * HT + 14, F_RGB, 9'h16D, "inv_paper_white");
        expectOut(20 * HT - 1, F_INT, 1, "int_before");
        expectOut(20 * HT, F_INT, 0, "int_first");
        expectOut(20 * HT + 31, F_INT, 0, "int_last");
        expectOut(20 * HT + 32, F_INT, 1, "int_after");
        expectOut(29 * HT + 100, F_SYNC, 3, "vsync_before");
        expectOut(30 * HT, F_SYNC, 2, "vsync_line30");
        expectOut(34 * HT, F_SYNC, 3, "vsync_after");
        expectOut(FR - 1, F_INTLOW, 32, "int_low_clocks");
        expectOut(FR - 1, F_INTFALL, 1, "int_pulse_count");
        expectAt(FR - 1, F_HC, HT - 1, "hCount_last");
        expectAt(FR - 1, F_VC, VT - 1, "vCount_last");
        expectAt(FR, F_HC, 0, "hCount_wrap");
        expectAt(FR, F_VC, 0, "vCount_wrap");
        expectAt(FR, F_FC, 1, "fCount_wrap");
        expectOut(FR + 3, F_RGB, 9'h140, "f1_border_h3");
        expectOut(FR + 13, F_RGB, 9'h16D, "f1_noflash_ink");
        expectOut(FR + 8 * HT + 13, F_RGB, 9'h000, "flash_f1_swapped0");
        expectOut(FR + 8 * HT + 14, F_RGB, 9'h16D, "flash_f1_swapped1");
        expectOut(FR + 20 * HT, F_INT, 0, "f1_int_first");
        expectOut(FR + 20 * HT + 10, F_INT, 0, "f1_int_mid");

        repeat (3) @(negedge clock);
        reset = 1'b0;

        n = 0;
        while (cyc != FR + 20 * HT + 11 && n < 40000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 40000) begin
            checks++;
            errors++;
            $display("FAIL mid_int_wait: cycle %0d, required %0d", cyc, FR + 20 * HT + 11);
        end

        // Reset mid-pulse: int must return high and counting restart at 0,0.
        reset = 1'b1;
        @(posedge clock);
        expectAt(0, F_INT, 1, "midreset_int");
        expectAt(0, F_HC, 0, "midreset_hCount");
        expectAt(0, F_VC, 0, "midreset_vCount");
        expectAt(0, F_FC, 0, "midreset_fCount");
        expectAt(0, F_RGB, 0, "midreset_rgb");
        expectOut(0, F_INT, 1, "post_int_p0");
        expectOut(0, F_SYNC, 3, "post_sync_p0");
        expectOut(4, F_MAYC, 0, "post_mayc_h4");
        expectOut(5, F_RGB, 9'h140, "post_border_h5");
        expectOut(13, F_RGB, 9'h16D, "post_pix0_ink");
        expectAt(5, F_HC, 5, "post_hCount5");
        @(negedge clock);
        reset = 1'b0;

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_checks: %0d left, required 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
